s_core_loader: RTL and testbench
================================

Name: s_core_loader

Overview:
Host-side program loader that sits directly upstream of s_core and drives its setup interface: instruction-memory writes, register preloads, start PC and the setup flag. It receives a byte stream over a valid/ready handshake, decodes fixed-format command packets, and emits one-cycle write strobes with stable address/data. After a start command it releases setup so the core runs from the programmed PC; a halt command returns the core to setup.

Parameters:
TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a packet before abort
CNT_W, 16, width of the instruction-write counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_rx_data  input  8  packet byte
i_rx_valid  input  1  i_rx_data valid
o_rx_ready  output  1  loader accepts byte; transfer occurs when valid&&ready at rising clk
o_setup  output  1  drives s_core setup
o_inst_mem_addr  output  32  instruction-memory write address
o_inst_mem_data  output  32  instruction word
o_inst_we  output  1  one-cycle instruction write strobe
o_load_reg_addr  output  5  register-file preload index
o_load_reg_data  output  32  register preload value
o_reg_we  output  1  one-cycle register write strobe
o_pc_instr_start_addr  output  32  start PC for s_core
o_busy  output  1  packet in progress
o_err  output  1  sticky error flag
o_inst_count  output  CNT_W  number of instruction writes since reset, saturating

Behaviour:
- Reset (async, rst=1): state IDLE; o_setup=1; o_rx_ready=1; all addr/data/start outputs 0; strobes 0; o_busy=0; o_err=0; o_inst_count=0. Reset mid-packet discards the partial packet; no strobe is emitted.
- Packets (multi-byte fields little-endian, first byte -> bits[7:0]):
  0x01 INST: 4 addr bytes + 4 data bytes.
  0x02 REG: 1 reg byte + 4 data bytes.
  0x03 START: 4 addr bytes.
  0x04 HALT: no payload.
- States: IDLE, ADDR (4-byte collect), DATA (4-byte collect), REG (1-byte collect), WRITE, RUN.
- IDLE (setup mode) on an accepted byte:
  0x01 -> ADDR, then DATA.
  0x02 -> REG, then DATA.
  0x03 -> ADDR.
  0x04 -> ignored (already in setup).
  Any other value -> o_err=1, stay IDLE.
- Byte counter is 2 bits and clears on every state entry.
- Completing INST or REG: state WRITE for exactly one cycle.
  - o_rx_ready=0 in WRITE.
  - The matching strobe (o_inst_we or o_reg_we) is high in that cycle.
  - Addr/data outputs update at the edge that accepts the last byte and hold until the next write of the same type.
- o_inst_count increments at the edge ending WRITE for INST only. It saturates at all-ones.
- REG byte with bits[7:5] != 0: o_err=1, packet aborted to IDLE, no strobe.
- START: o_pc_instr_start_addr loads at the edge accepting the 4th addr byte. o_setup falls at the next edge, so the address is stable one cycle before setup drops. Then state RUN.
- RUN: o_setup=0, o_rx_ready=1.
  - 0x04 -> o_setup=1 at the next edge, state IDLE.
  - Any other byte -> o_err=1, stay RUN, setup unchanged.
- o_busy=1 in ADDR, DATA, REG and WRITE.
- Timeout: an idle counter resets on each accepted byte and counts cycles while in ADDR/DATA/REG with no transfer. When it reaches TIMEOUT_CYCLES: o_err=1, return to IDLE, no strobe, outputs unchanged.
- o_err is cleared only by rst.
- o_rx_ready does not depend combinationally on i_rx_valid.

Test Plan:
- Send 01 04 00 00 00 13 74 12 00 -> one cycle after the last byte, o_inst_we=1 for exactly 1 cycle with addr=0x00000004, data=0x00127413; o_inst_count=1; o_setup stays 1.
- Send 02 04 01 00 00 00 then 02 06 01 00 00 00 -> two o_reg_we pulses: (addr 4, data 0x1) and (addr 6, data 0x1); o_inst_count unchanged.
- Send 03 04 00 00 00 -> o_pc_instr_start_addr=0x4 at the last-byte edge, o_setup=0 exactly one cycle later; then send 04 -> o_setup=1 next cycle, state IDLE.
- Send 7F, then a valid INST packet -> o_err=1 after 7F; the INST write still completes; o_err stays 1. Send 02 20 in a separate run -> o_err=1, no o_reg_we.
- Send 01 04 00, then hold i_rx_valid=0 for TIMEOUT_CYCLES cycles -> o_err=1, o_busy=0, no strobe. The next packet decodes from a fresh command byte.
- Assert rst after 5 bytes of an INST packet -> all outputs return to reset values immediately (async); no strobe; a following full packet writes correctly with o_inst_count=1.

Source files
------------

// File: rtl/s_core_loader.sv
// Byte-stream program loader for s_core: decodes INST/REG/START/HALT packets and
// drives the core's setup interface with one-cycle write strobes.
module s_core_loader #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_setup,
  output logic [31:0]      o_inst_mem_addr,
  output logic [31:0]      o_inst_mem_data,
  output logic             o_inst_we,
  output logic [4:0]       o_load_reg_addr,
  output logic [31:0]      o_load_reg_data,
  output logic             o_reg_we,
  output logic [31:0]      o_pc_instr_start_addr,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_inst_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_REG   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;

  localparam logic [1:0] C_INST  = 2'd0;
  localparam logic [1:0] C_REG   = 2'd1;
  localparam logic [1:0] C_START = 2'd2;

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       r_state;
  logic [1:0]       r_cmd;
  logic [1:0]       r_byte_cnt;
  logic [31:0]      r_shift;
  logic [31:0]      r_addr;
  logic [4:0]       r_reg;
  logic [TO_W-1:0]  r_idle_cnt;
  logic             r_setup;
  logic             r_err;
  logic [31:0]      r_inst_addr;
  logic [31:0]      r_inst_data;
  logic [4:0]       r_load_addr;
  logic [31:0]      r_load_data;
  logic [31:0]      r_pc_start;
  logic [CNT_W-1:0] r_inst_count;

  logic        w_xfer;
  logic        w_collect;
  logic        w_timeout;
  logic [31:0] w_word;

  assign w_xfer    = i_rx_valid && o_rx_ready;
  assign w_collect = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_REG);
  assign w_timeout = w_collect && !w_xfer && (r_idle_cnt == TO_LAST);
  // Little-endian assembly: the current byte lands in the top lane of the word.
  assign w_word    = {i_rx_data, r_shift[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= C_INST;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 32'd0;
      r_addr       <= 32'd0;
      r_reg        <= 5'd0;
      r_idle_cnt   <= '0;
      r_setup      <= 1'b1;
      r_err        <= 1'b0;
      r_inst_addr  <= 32'd0;
      r_inst_data  <= 32'd0;
      r_load_addr  <= 5'd0;
      r_load_data  <= 32'd0;
      r_pc_start   <= 32'd0;
      r_inst_count <= '0;
    end else begin
      if (w_collect && !w_xfer) r_idle_cnt <= r_idle_cnt + TO_ONE;
      else                      r_idle_cnt <= '0;

      if (w_timeout) begin
        r_err      <= 1'b1;
        r_state    <= S_IDLE;
        r_byte_cnt <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_xfer) begin
              r_byte_cnt <= 2'd0;
              case (i_rx_data)
                8'h01: begin r_cmd <= C_INST;  r_state <= S_ADDR; end
                8'h02: begin r_cmd <= C_REG;   r_state <= S_REG;  end
                8'h03: begin r_cmd <= C_START; r_state <= S_ADDR; end
                8'h04: ;
                default: r_err <= 1'b1;
              endcase
            end
          end
          S_ADDR: begin
            if (w_xfer) begin
              r_shift <= w_word;
              if (r_byte_cnt == 2'd3) begin
                r_byte_cnt <= 2'd0;
                if (r_cmd == C_START) begin
                  // Setup drops one edge later in RUN, so the PC is stable first.
                  r_pc_start <= w_word;
                  r_state    <= S_RUN;
                end else begin
                  r_addr  <= w_word;
                  r_state <= S_DATA;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end
          end
          S_DATA: begin
            if (w_xfer) begin
              r_shift <= w_word;
              if (r_byte_cnt == 2'd3) begin
                r_byte_cnt <= 2'd0;
                r_state    <= S_WRITE;
                if (r_cmd == C_INST) begin
                  r_inst_addr <= r_addr;
                  r_inst_data <= w_word;
                end else begin
                  r_load_addr <= r_reg;
                  r_load_data <= w_word;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end
          end
          S_REG: begin
            if (w_xfer) begin
              r_byte_cnt <= 2'd0;
              if (i_rx_data[7:5] != 3'd0) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_reg   <= i_rx_data[4:0];
                r_state <= S_DATA;
              end
            end
          end
          S_WRITE: begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            if ((r_cmd == C_INST) && (r_inst_count != {CNT_W{1'b1}}))
              r_inst_count <= r_inst_count + CNT_ONE;
          end
          S_RUN: begin
            r_setup <= 1'b0;
            if (w_xfer) begin
              if (i_rx_data == 8'h04) begin
                r_setup    <= 1'b1;
                r_state    <= S_IDLE;
                r_byte_cnt <= 2'd0;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
          end
        endcase
      end
    end
  end

  assign o_rx_ready            = (r_state != S_WRITE);
  assign o_busy                = w_collect || (r_state == S_WRITE);
  assign o_inst_we             = (r_state == S_WRITE) && (r_cmd == C_INST);
  assign o_reg_we              = (r_state == S_WRITE) && (r_cmd == C_REG);
  assign o_setup               = r_setup;
  assign o_err                 = r_err;
  assign o_inst_mem_addr       = r_inst_addr;
  assign o_inst_mem_data       = r_inst_data;
  assign o_load_reg_addr       = r_load_addr;
  assign o_load_reg_data       = r_load_data;
  assign o_pc_instr_start_addr = r_pc_start;
  assign o_inst_count          = r_inst_count;

endmodule

// File: tb/tb_s_core_loader.sv
// Self-checking bench for s_core_loader: directed packet table, hand-written
// corner sequences and a randomized packet stream against a packet-level model.
module tb_s_core_loader;

  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready, o_setup, o_inst_we, o_reg_we, o_busy, o_err;
  logic [31:0]   o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_instr_start_addr;
  logic [4:0]    o_load_reg_addr;
  logic [CW-1:0] o_inst_count;

  always #5 clk = ~clk;

  s_core_loader #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_setup(o_setup),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data), .o_inst_we(o_inst_we),
    .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data), .o_reg_we(o_reg_we),
    .o_pc_instr_start_addr(o_pc_instr_start_addr),
    .o_busy(o_busy), .o_err(o_err), .o_inst_count(o_inst_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } ev_t;
  ev_t q_inst[$];
  ev_t q_reg[$];

  typedef struct packed {
    logic        is_inst;
    logic [3:0]  nb;
    logic [71:0] bytes;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  // Observed strobes; a pulse wider than one cycle shows up as a duplicate entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_inst_we) q_inst.push_back({o_inst_mem_addr, o_inst_mem_data});
      if (o_reg_we)  q_reg.push_back({27'd0, o_load_reg_addr, o_load_reg_data});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " setup"}, 64'(o_setup), 64'd1);
    check({tag, " ready"}, 64'(o_rx_ready), 64'd1);
    check({tag, " busy"}, 64'(o_busy), 64'd0);
    check({tag, " err"}, 64'(o_err), 64'd0);
    check({tag, " cnt"}, 64'(o_inst_count), 64'd0);
    check({tag, " strobes"}, {62'd0, o_inst_we, o_reg_we}, 64'd0);
    check({tag, " iaddr/idata"}, {o_inst_mem_addr, o_inst_mem_data}, 64'd0);
    check({tag, " raddr/rdata"}, {27'd0, o_load_reg_addr, o_load_reg_data}, 64'd0);
    check({tag, " pc"}, 64'(o_pc_instr_start_addr), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    q_inst.delete();
    q_reg.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one byte and returns 1 time unit after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles expected ready=1");
    end
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [71:0] bytes, input int nb, input int maxgap);
    for (int i = 0; i < nb; i++) begin
      if (i > 0 && maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
      send_byte(bytes[8*i +: 8]);
    end
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_cnt;
    logic [31:0] a, d;
    logic [4:0]  r;
    logic [7:0]  b;
    logic        m_run, m_err;
    int          m_cnt;
    logic [31:0] m_pc;
    ev_t         e_inst[$];
    ev_t         e_reg[$];

    vecs[0] = '{1'b1, 4'd9, 72'h00_12_74_13_00_00_00_04_01, 32'h0000_0004, 32'h0012_7413};
    vecs[1] = '{1'b0, 4'd6, 72'h00_00_00_00_00_01_04_02, 32'd4, 32'h1};
    vecs[2] = '{1'b0, 4'd6, 72'h00_00_00_00_00_01_06_02, 32'd6, 32'h1};
    vecs[3] = '{1'b1, 4'd9, 72'hDE_AD_BE_EF_12_34_56_78_01, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 4'd6, 72'h00_A5_5A_C3_3C_1F_02, 32'd31, 32'hA55A_C33C};

    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed packet table.
    exp_cnt = 0;
    foreach (vecs[k]) begin
      send_pkt(vecs[k].bytes, int'(vecs[k].nb), 0);
      check($sformatf("vec%0d inst_we", k), 64'(o_inst_we), 64'(vecs[k].is_inst));
      check($sformatf("vec%0d reg_we", k), 64'(o_reg_we), 64'(!vecs[k].is_inst));
      check($sformatf("vec%0d ready/busy", k), {62'd0, o_rx_ready, o_busy}, 64'b01);
      if (vecs[k].is_inst)
        check($sformatf("vec%0d inst addr/data", k), {o_inst_mem_addr, o_inst_mem_data},
              {vecs[k].addr, vecs[k].data});
      else
        check($sformatf("vec%0d reg addr/data", k), {27'd0, o_load_reg_addr, o_load_reg_data},
              {vecs[k].addr, vecs[k].data});
      check($sformatf("vec%0d cnt in write", k), 64'(o_inst_count), 64'(exp_cnt));
      @(posedge clk);
      #1;
      if (vecs[k].is_inst) exp_cnt++;
      check($sformatf("vec%0d strobes after", k), {62'd0, o_inst_we, o_reg_we}, 64'd0);
      check($sformatf("vec%0d cnt after", k), 64'(o_inst_count), 64'(exp_cnt));
      check($sformatf("vec%0d setup", k), 64'(o_setup), 64'd1);
    end

    // START then HALT.
    send_pkt(72'h00_00_00_00_04_03, 5, 0);
    check("start pc", 64'(o_pc_instr_start_addr), 64'h4);
    check("start setup still 1", 64'(o_setup), 64'd1);
    @(posedge clk);
    #1;
    check("start setup drops", 64'(o_setup), 64'd0);
    check("run ready", 64'(o_rx_ready), 64'd1);
    send_byte(8'h04);
    check("halt setup", 64'(o_setup), 64'd1);
    check("halt busy/err", {62'd0, o_busy, o_err}, 64'd0);

    // Bad command, then INST still works; err sticky.
    do_reset();
    send_byte(8'h7F);
    check("badcmd err", 64'(o_err), 64'd1);
    send_pkt(vecs[3].bytes, 9, 0);
    check("after badcmd inst_we", 64'(o_inst_we), 64'd1);
    check("after badcmd addr", 64'(o_inst_mem_addr), 64'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    check("err sticky", 64'(o_err), 64'd1);

    // Bad register index aborts without a strobe.
    do_reset();
    send_pkt(72'h20_02, 2, 0);
    check("badreg err/busy", {62'd0, o_err, o_busy}, 64'b10);
    repeat (3) @(posedge clk);
    #1;
    check("badreg no strobe", 64'(q_reg.size()), 64'd0);

    // Timeout inside a packet.
    do_reset();
    send_pkt(72'h00_04_01, 3, 0);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("pre-timeout busy/err", {62'd0, o_busy, o_err}, 64'b10);
    @(posedge clk);
    #1;
    check("timeout busy/err", {62'd0, o_busy, o_err}, 64'b01);
    send_pkt(vecs[0].bytes, 9, 0);
    repeat (2) @(posedge clk);
    #1;
    check("post-timeout writes", 64'(q_inst.size()), 64'd1);
    if (q_inst.size() == 1)
      check("post-timeout data", q_inst[0], {32'h4, 32'h0012_7413});
    check("post-timeout cnt", 64'(o_inst_count), 64'd1);

    // Asynchronous reset in the middle of an INST packet.
    send_pkt(vecs[3].bytes, 5, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    q_inst.delete();
    q_reg.delete();
    @(negedge clk);
    rst = 1'b0;
    send_pkt(vecs[3].bytes, 9, 0);
    repeat (2) @(posedge clk);
    #1;
    check("after async writes", 64'(q_inst.size()), 64'd1);
    check("after async cnt", 64'(o_inst_count), 64'd1);

    // Counter saturation at all-ones.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      a = 32'(k);
      d = $urandom;
      send_pkt({d, a, 8'h01}, 9, 0);
      @(posedge clk);
      #1;
      if (k >= 13) check($sformatf("sat cnt k=%0d", k), 64'(o_inst_count),
                         64'((k + 1 > 15) ? 15 : k + 1));
    end

    // Randomized packet stream against the packet-level model.
    do_reset();
    m_run = 1'b0; m_err = 1'b0; m_cnt = 0; m_pc = 32'd0;
    for (int p = 0; p < 60; p++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if (!m_run) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin
            a = $urandom; d = $urandom;
            send_pkt({d, a, 8'h01}, 9, 2);
            e_inst.push_back({a, d});
            m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
          end
          4, 5: begin
            r = 5'($urandom_range(0, 31)); d = $urandom;
            send_pkt({24'd0, d, 3'd0, r, 8'h02}, 6, 2);
            e_reg.push_back({27'd0, r, d});
          end
          6: begin
            a = $urandom;
            send_pkt({32'd0, a, 8'h03}, 5, 2);
            m_pc = a; m_run = 1'b1;
          end
          7: send_byte(8'h04);
          8: begin
            b = 8'($urandom_range(5, 255));
            send_byte(b);
            m_err = 1'b1;
          end
          default: begin
            b = {3'($urandom_range(1, 7)), 5'($urandom)};
            send_pkt({56'd0, b, 8'h02}, 2, 2);
            m_err = 1'b1;
          end
        endcase
      end else begin
        if ($urandom_range(0, 2) != 0) begin
          send_byte(8'h04);
          m_run = 1'b0;
        end else begin
          b = 8'($urandom_range(5, 255));
          send_byte(b);
          m_err = 1'b1;
        end
      end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("rnd%0d setup/err", p), {62'd0, o_setup, o_err}, {62'd0, !m_run, m_err});
      check($sformatf("rnd%0d cnt", p), 64'(o_inst_count), 64'(m_cnt));
      check($sformatf("rnd%0d pc", p), 64'(o_pc_instr_start_addr), 64'(m_pc));
      check($sformatf("rnd%0d nwrites", p), {32'(q_inst.size()), 32'(q_reg.size())},
            {32'(e_inst.size()), 32'(e_reg.size())});
    end
    if (q_inst.size() == e_inst.size())
      foreach (e_inst[k]) check($sformatf("rnd inst ev%0d", k), q_inst[k], e_inst[k]);
    if (q_reg.size() == e_reg.size())
      foreach (e_reg[k]) check($sformatf("rnd reg ev%0d", k), q_reg[k], e_reg[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
